sensor_frontend: RTL and testbench

- Producer side of the sensor-flag interface consumed by the LED/relay controller.
- Drives the ultrasonic ranger trigger and measures its echo width to produce senal_distancia.
- Synchronizes and debounces the raw sound-sensor output, then stretches each sound event into senal_sonido.
- Synchronizes and debounces the raw alcohol-sensor output into senal_alcohol.
- All outputs are registered and level-stable, so the controller can sample them on any clk edge.

---
 rtl/sensor_frontend_pkg.sv | 24 ++
 rtl/sensor_frontend_sync_debounce.sv | 53 +++++
 rtl/sensor_frontend.sv | 179 +++++++++++++++++
 tb/tb_sensor_frontend.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_frontend_pkg.sv
// Shared constants for the sensor front end: ranging FSM encodings,
// default timing for a 50 MHz clk, and a small width helper.
package sensor_frontend_pkg;

    // Ranging FSM state encodings
    localparam logic [1:0] ST_TRIG      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_HOLDOFF   = 2'd3;

    localparam int unsigned CLK_HZ = 50_000_000;

    localparam int unsigned DEF_TRIG_CYCLES       = CLK_HZ / 100_000;     // 10 us
    localparam int unsigned DEF_PERIOD_CYCLES     = (CLK_HZ / 1000) * 60; // 60 ms
    localparam int unsigned DEF_ECHO_TIMEOUT      = (CLK_HZ / 1000) * 30; // 30 ms
    localparam int unsigned DEF_NEAR_CYCLES       = 87_000;               // ~30 cm round trip
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = CLK_HZ / 100;         // 10 ms
    localparam int unsigned DEF_SOUND_HOLD_CYCLES = CLK_HZ / 2;           // 0.5 s

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sensor_frontend_sync_debounce.sv
// 2-FF synchronizer followed by a debounce counter. The output only takes a
// new level after the synchronized input has held it for DEBOUNCE_CYCLES.
module sensor_frontend_sync_debounce
    import sensor_frontend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_raw,
    output logic out_level
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // For a 1-bit input, "differs from last sample" while a change is pending
    // is the same as "equals the current output", so that single compare
    // restarts the count on every bounce.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_level = level_q;

endmodule

// File: rtl/sensor_frontend.sv
// Sensor front end: ultrasonic ranging FSM, stretched sound flag and
// debounced alcohol flag, all registered for the LED/relay controller.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TRIG      | trig high for TRIG_CYCLES
// WAIT_RISE | wait for synchronized echo 0->1, timeout gives far
// MEASURE   | count echo high width, fall or timeout gives the result
// HOLDOFF   | echo ignored until the period counter wraps
module sensor_frontend
    import sensor_frontend_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES       = DEF_TRIG_CYCLES,
    parameter int unsigned PERIOD_CYCLES     = DEF_PERIOD_CYCLES,
    parameter int unsigned ECHO_TIMEOUT      = DEF_ECHO_TIMEOUT,
    parameter int unsigned NEAR_CYCLES       = DEF_NEAR_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SOUND_HOLD_CYCLES = DEF_SOUND_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic echo,
    input  logic sonido_raw,
    input  logic alcohol_raw,
    output logic trig,
    output logic senal_distancia,
    output logic senal_sonido,
    output logic senal_alcohol,
    output logic dist_valid
);

    localparam int unsigned CW = $clog2(max_u(max_u(TRIG_CYCLES, ECHO_TIMEOUT), NEAR_CYCLES) + 1);
    localparam int unsigned PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned HW = $clog2(SOUND_HOLD_CYCLES + 1);

    localparam logic [CW-1:0] TRIG_C    = CW'(TRIG_CYCLES);
    localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW:0]   NEAR_W    = (CW+1)'(NEAR_CYCLES);
    localparam logic [CW:0]   MEAS_LAST = (CW+1)'(ECHO_TIMEOUT - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_C    = HW'(SOUND_HOLD_CYCLES);

    logic          echo_s1_q, echo_s2_q, echo_prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] per_q, per_d;
    logic          trig_q, trig_d;
    logic          dist_q, dist_d;
    logic          valid_q, valid_d;
    logic          snd_db, snd_prev_q, sonido_q, sonido_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          alc_db;
    logic          echo_rise, per_wrap;
    logic [CW:0]   width_c;

    sensor_frontend_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_snd_db (
        .clk(clk), .rst_n(rst_n), .in_raw(sonido_raw), .out_level(snd_db)
    );

    sensor_frontend_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_alc_db (
        .clk(clk), .rst_n(rst_n), .in_raw(alcohol_raw), .out_level(alc_db)
    );

    assign echo_rise = echo_s2_q & ~echo_prev_q;
    assign per_wrap  = (per_q == PER_LAST);
    // Echo width including the cycle on which the rise was detected.
    assign width_c   = {1'b0, cnt_q} + 1'b1;

    // Ranging FSM next state, trigger, and distance result
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        dist_d  = dist_q;
        valid_d = 1'b0;
        per_d   = per_wrap ? '0 : per_q + 1'b1;
        case (state_q)
            ST_TRIG: begin
                if (cnt_q == TRIG_C) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    trig_d = 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_HOLDOFF;
                    dist_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!echo_s2_q) begin
                    state_d = ST_HOLDOFF;
                    dist_d  = (width_c < NEAR_W);
                    valid_d = 1'b1;
                end else if (width_c == MEAS_LAST) begin
                    state_d = ST_HOLDOFF;
                    dist_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
            end
            default: state_d = ST_TRIG;
        endcase
        // A wrap with a measurement still open only happens with inconsistent
        // parameters; report far so the controller never sees a stale result.
        if (per_wrap) begin
            if ((state_q == ST_WAIT_RISE || state_q == ST_MEASURE) && state_d != ST_HOLDOFF) begin
                dist_d  = 1'b0;
                valid_d = 1'b1;
            end
            state_d = ST_TRIG;
            cnt_d   = '0;
            trig_d  = 1'b0;
        end
    end

    // Sound stretch: a rise (re)loads the hold, a low level drains it
    always_comb begin
        hold_d   = hold_q;
        sonido_d = sonido_q;
        if (snd_db && !snd_prev_q) begin
            hold_d   = HOLD_C;
            sonido_d = 1'b1;
        end else if (!snd_db && hold_q != '0) begin
            hold_d   = hold_q - 1'b1;
            sonido_d = (hold_q != HW'(1));
        end
    end

    // Registered state for echo sync, ranging, and sound hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1_q   <= 1'b0;
            echo_s2_q   <= 1'b0;
            echo_prev_q <= 1'b0;
            state_q     <= ST_TRIG;
            cnt_q       <= '0;
            per_q       <= '0;
            trig_q      <= 1'b0;
            dist_q      <= 1'b0;
            valid_q     <= 1'b0;
            snd_prev_q  <= 1'b0;
            hold_q      <= '0;
            sonido_q    <= 1'b0;
        end else begin
            echo_s1_q   <= echo;
            echo_s2_q   <= echo_s1_q;
            echo_prev_q <= echo_s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            trig_q      <= trig_d;
            dist_q      <= dist_d;
            valid_q     <= valid_d;
            snd_prev_q  <= snd_db;
            hold_q      <= hold_d;
            sonido_q    <= sonido_d;
        end
    end

    assign trig            = trig_q;
    assign senal_distancia = dist_q;
    assign dist_valid      = valid_q;
    assign senal_sonido    = sonido_q;
    assign senal_alcohol   = alc_db;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend with small timing parameters.
module tb_sensor_frontend;

    logic clk = 1'b0;
    logic rst_n, echo, sonido_raw, alcohol_raw;
    logic trig, senal_distancia, senal_sonido, senal_alcohol, dist_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int   width;
        logic near;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    sensor_frontend #(
        .TRIG_CYCLES(4), .PERIOD_CYCLES(200), .ECHO_TIMEOUT(100),
        .NEAR_CYCLES(20), .DEBOUNCE_CYCLES(8), .SOUND_HOLD_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .echo(echo), .sonido_raw(sonido_raw),
        .alcohol_raw(alcohol_raw), .trig(trig), .senal_distancia(senal_distancia),
        .senal_sonido(senal_sonido), .senal_alcohol(senal_alcohol), .dist_valid(dist_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench one tick after the edge that raised trig.
    task automatic wait_trig_rise();
        int n = 0;
        while (trig !== 1'b0 && n < 500) begin tick(); n++; end
        while (trig !== 1'b1 && n < 1000) begin tick(); n++; end
        check("trig_rise_seen", {31'b0, trig}, 32'd1);
    endtask

    // Echo raised 5 cycles after trig falls, held w cycles; result 3 cycles after the fall.
    task automatic run_echo(input int w, input logic exp, input logic prev);
        wait_trig_rise();
        tickn(9);
        echo = 1'b1;
        tickn(w);
        check($sformatf("w%0d_dist_held", w), {31'b0, senal_distancia}, {31'b0, prev});
        echo = 1'b0;
        tickn(2);
        check($sformatf("w%0d_valid_early", w), {31'b0, dist_valid}, 32'd0);
        tick();
        check($sformatf("w%0d_valid", w), {31'b0, dist_valid}, 32'd1);
        check($sformatf("w%0d_dist", w), {31'b0, senal_distancia}, {31'b0, exp});
        tick();
        check($sformatf("w%0d_valid_end", w), {31'b0, dist_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   highs;
        logic prev;

        vecs[0] = '{10, 1'b1};
        vecs[1] = '{30, 1'b0};
        vecs[2] = '{20, 1'b0};
        vecs[3] = '{19, 1'b1};
        vecs[4] = '{21, 1'b0};
        vecs[5] = '{1,  1'b1};
        vecs[6] = '{40, 1'b0};
        vecs[7] = '{5,  1'b1};

        rst_n = 1'b0; echo = 1'b0; sonido_raw = 1'b0; alcohol_raw = 1'b0;
        tickn(3);
        check("rst_trig",   {31'b0, trig},            32'd0);
        check("rst_dist",   {31'b0, senal_distancia}, 32'd0);
        check("rst_valid",  {31'b0, dist_valid},      32'd0);
        check("rst_sonido", {31'b0, senal_sonido},    32'd0);
        check("rst_alc",    {31'b0, senal_alcohol},   32'd0);

        // Scenario 1: no echo, timeout result and period spacing
        rst_n = 1'b1;
        tick();     check("t1_trig_f1",   {31'b0, trig}, 32'd1);
        tickn(3);   check("t1_trig_f4",   {31'b0, trig}, 32'd1);
        tick();     check("t1_trig_f5",   {31'b0, trig}, 32'd0);
        tickn(99);  check("t1_valid_104", {31'b0, dist_valid}, 32'd0);
        tick();     check("t1_valid_105", {31'b0, dist_valid}, 32'd1);
                    check("t1_dist_105",  {31'b0, senal_distancia}, 32'd0);
        tick();     check("t1_valid_106", {31'b0, dist_valid}, 32'd0);
        tickn(94);  check("t1_trig_200",  {31'b0, trig}, 32'd0);
        tick();     check("t1_trig_201",  {31'b0, trig}, 32'd1);

        // Scenarios 2/3: echo width table
        prev = 1'b0;
        foreach (vecs[i]) begin
            run_echo(vecs[i].width, vecs[i].near, prev);
            prev = vecs[i].near;
        end

        // Echo already high before trig: no rise, timeout gives far
        echo = 1'b1;
        wait_trig_rise();
        tickn(103); check("stuck_valid_early", {31'b0, dist_valid}, 32'd0);
                    check("stuck_dist_held",   {31'b0, senal_distancia}, 32'd1);
        tick();     check("stuck_valid", {31'b0, dist_valid}, 32'd1);
                    check("stuck_dist",  {31'b0, senal_distancia}, 32'd0);
        echo = 1'b0;

        // Scenario 4: short glitch is filtered
        sonido_raw = 1'b1;
        tickn(5);
        sonido_raw = 1'b0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (senal_sonido) highs++;
        end
        check("snd_glitch_highs", highs, 32'd0);

        // 10-cycle pulse: rises 11 cycles after raw rise, drops at 70
        sonido_raw = 1'b1;
        tickn(10);  check("snd_e10", {31'b0, senal_sonido}, 32'd0);
        sonido_raw = 1'b0;
        tick();     check("snd_e11", {31'b0, senal_sonido}, 32'd1);
        tickn(58);  check("snd_e69", {31'b0, senal_sonido}, 32'd1);
        tick();     check("snd_e70", {31'b0, senal_sonido}, 32'd0);

        // Retrigger mid-hold extends the high time to 100
        sonido_raw = 1'b1;
        tickn(10);
        sonido_raw = 1'b0;
        tickn(20);
        sonido_raw = 1'b1;
        tickn(10);
        sonido_raw = 1'b0;
        tickn(31);  check("snd_rt_e71",  {31'b0, senal_sonido}, 32'd1);
        tickn(28);  check("snd_rt_e99",  {31'b0, senal_sonido}, 32'd1);
        tick();     check("snd_rt_e100", {31'b0, senal_sonido}, 32'd0);

        // Scenario 5: alcohol chatter then steady high
        highs = 0;
        for (int k = 0; k < 14; k++) begin
            alcohol_raw = (k % 2 == 0);
            for (int j = 0; j < 3; j++) begin
                tick();
                if (senal_alcohol) highs++;
            end
        end
        check("alc_chatter_highs", highs, 32'd0);
        alcohol_raw = 1'b1;
        tickn(9);   check("alc_rise_l9",  {31'b0, senal_alcohol}, 32'd0);
        tick();     check("alc_rise_l10", {31'b0, senal_alcohol}, 32'd1);
        alcohol_raw = 1'b0;
        tickn(9);   check("alc_fall_l9",  {31'b0, senal_alcohol}, 32'd1);
        tick();     check("alc_fall_l10", {31'b0, senal_alcohol}, 32'd0);
        alcohol_raw = 1'b1;
        tickn(10);  check("alc_high_again", {31'b0, senal_alcohol}, 32'd1);

        // Scenario 6: async reset during MEASURE with senal_distancia=1
        run_echo(10, 1'b1, 1'b0);
        sonido_raw = 1'b1;
        wait_trig_rise();
        tickn(9);
        echo = 1'b1;
        tickn(8);
        check("pre_rst_dist",   {31'b0, senal_distancia}, 32'd1);
        check("pre_rst_sonido", {31'b0, senal_sonido},    32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_trig",   {31'b0, trig},            32'd0);
        check("mid_rst_dist",   {31'b0, senal_distancia}, 32'd0);
        check("mid_rst_valid",  {31'b0, dist_valid},      32'd0);
        check("mid_rst_sonido", {31'b0, senal_sonido},    32'd0);
        check("mid_rst_alc",    {31'b0, senal_alcohol},   32'd0);
        #2;
        echo  = 1'b0;
        rst_n = 1'b1;
        tick();     check("post_rst_trig_f1", {31'b0, trig}, 32'd1);
        tickn(3);   check("post_rst_trig_f4", {31'b0, trig}, 32'd1);
        tick();     check("post_rst_trig_f5", {31'b0, trig}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
